// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NREQ byte sources.
// Grants one source at a time, pulses tx_rq, and reports completion or start timeout.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned SIZE         = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*SIZE-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           done,
    output logic                      tx_rq,
    output logic [SIZE-1:0]           tx_data,
    input  logic                      tx_busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      timeout_err
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_END,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [TW-1:0]   timer;

    logic [SIZE-1:0] src_byte [NREQ];
    logic            win_found;
    logic [PW-1:0]   win_idx;
    int unsigned     scan_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign src_byte[g] = req_data[g*SIZE +: SIZE];
    end

    // First valid source scanning ptr, ptr+1, ... with explicit wrap so non-power-of-2 NREQ works.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!win_found && req_valid[PW'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(scan_idx);
            end
        end
    end

    // Scheduler FSM; pulse outputs default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            timer       <= '0;
            req_ready   <= '0;
            done        <= '0;
            tx_rq       <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ready   <= '0;
            done        <= '0;
            tx_rq       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && !tx_busy) begin
                        tx_data   <= src_byte[win_idx];
                        grant_id  <= win_idx;
                        req_ready <= NREQ'(1) << win_idx;
                        tx_rq     <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    // A busy rise on the last timer cycle still counts as a start.
                    if (tx_busy) begin
                        state <= WAIT_END;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= NREQ'(1) << grant_id;
                        state       <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_END: begin
                    if (!tx_busy) begin
                        done  <= NREQ'(1) << grant_id;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// checked against a transaction-level round-robin model and a behavioural TX stub.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int SIZE = 8;
    localparam int BT   = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ*SIZE-1:0]    req_data = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         done;
    logic                    tx_rq;
    logic [SIZE-1:0]         tx_data;
    logic                    tx_busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    timeout_err;

    uart_tx_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .done(done), .tx_rq(tx_rq), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural TX stub: busy rises stub_sd cycles after the tx_rq cycle, lasts stub_len cycles.
    logic            tx_force  = 1'b0;
    logic            mbusy     = 1'b0;
    bit              stub_dead = 1'b0;
    int              stub_sd   = 0;
    int              stub_len  = 4;
    bit              pend      = 1'b0;
    int              dly       = 0;
    int              left      = 0;
    int              lenl      = 0;
    int              fall_cyc  = 0;
    logic [SIZE-1:0] last_sent = '0;

    assign tx_busy = tx_force | mbusy;

    always begin
        @(posedge clk);
        #1;
        if (mbusy) begin
            if (left <= 1) begin
                mbusy    = 1'b0;
                fall_cyc = cyc;
            end else begin
                left--;
            end
        end else if (pend) begin
            if (dly == 0) begin
                mbusy = 1'b1;
                left  = lenl;
                pend  = 1'b0;
            end else begin
                dly--;
            end
        end
        if (tx_rq && !stub_dead) begin
            pend      = 1'b1;
            dly       = stub_sd;
            lenl      = stub_len;
            last_sent = tx_data;
        end
    end

    // Protocol invariants: no request into a busy TX, one frame outstanding, done only for a live frame.
    bit outstanding = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 1'b0;
        end else begin
            if (tx_rq) begin
                check("rq_while_busy", 32'(tx_busy), 32'(0));
                check("rq_outstanding", 32'(outstanding), 32'(0));
                outstanding = 1'b1;
            end
            if (done != '0) begin
                check("done_without_frame", 32'(outstanding), 32'(1));
                outstanding = 1'b0;
            end
        end
    end

    // Reference model state.
    logic [SIZE-1:0] data_q [NREQ];
    int              mptr      = 0;
    int              last_wait = 0;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) req_data[i*SIZE +: SIZE] = data_q[i];
    endtask

    function automatic int scan();
        for (int k = 0; k < NREQ; k++) begin
            int i = (mptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return 0;
    endfunction

    task automatic raise(input int s, input logic [SIZE-1:0] b);
        req_valid[s] = 1'b1;
        data_q[s]    = b;
        drive();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_tx_rq"}, 32'(tx_rq), 32'(0));
        check({tag, "_tx_data"}, 32'(tx_data), 32'(0));
        check({tag, "_grant_id"}, 32'(grant_id), 32'(0));
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mptr  = 0;
    endtask

    // One frame for expected source s; returns at the negedge of the IDLE cycle after done.
    task automatic serve_one(input int s, input bit exp_to, input bit keep);
        logic [SIZE-1:0] b;
        int              n;
        int              rq_cyc;
        b = data_q[s];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 200);
        last_wait = n;
        check("grant_ready", 32'(req_ready), 32'(1) << s);
        if (req_ready == '0) return;
        check("grant_tx_rq", 32'(tx_rq), 32'(1));
        check("grant_tx_data", 32'(tx_data), 32'(b));
        check("grant_id", 32'(grant_id), 32'(s));
        rq_cyc = cyc;
        if (keep) begin
            data_q[s] = SIZE'($urandom);
        end else begin
            req_valid[s] = 1'b0;
            data_q[s]    = SIZE'($urandom);
        end
        drive();
        @(negedge clk);
        check("issue_ready_clear", 32'(req_ready), 32'(0));
        check("issue_rq_clear", 32'(tx_rq), 32'(0));
        n = 0;
        while (done == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_onehot", 32'(done), 32'(1) << s);
        check("done_timeout_err", 32'(timeout_err), 32'(exp_to));
        check("done_tx_data_held", 32'(tx_data), 32'(b));
        if (exp_to) begin
            check("timeout_latency", 32'(cyc), 32'(rq_cyc + BT + 1));
        end else begin
            check("done_latency", 32'(cyc), 32'(fall_cyc + 1));
            check("tx_received", 32'(last_sent), 32'(b));
        end
        mptr = (s + 1) % NREQ;
        @(negedge clk);
        check("gap_done_clear", 32'(done), 32'(0));
        check("gap_ready_clear", 32'(req_ready), 32'(0));
        check("gap_timeout_clear", 32'(timeout_err), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) data_q[i] = '0;
        drive();
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Single request from source 0.
        stub_sd  = 1;
        stub_len = 10;
        raise(0, 8'hA5);
        serve_one(0, 1'b0, 1'b0);
        check("first_grant_latency", 32'(last_wait), 32'(1));

        // All four sources at once, from ptr 0.
        do_reset();
        raise(0, 8'h11); raise(1, 8'h22); raise(2, 8'h33); raise(3, 8'h44);
        for (int k = 0; k < NREQ; k++) begin
            stub_sd  = k;
            stub_len = 3 + k;
            serve_one(scan(), 1'b0, 1'b0);
        end

        // Source 0 held valid, source 2 alternates with it.
        do_reset();
        raise(0, 8'h01); raise(2, 8'h02);
        serve_one(scan(), 1'b0, 1'b1);
        serve_one(scan(), 1'b0, 1'b0);
        raise(2, 8'h03);
        serve_one(scan(), 1'b0, 1'b0);
        serve_one(scan(), 1'b0, 1'b0);

        // Start timeout, then the next pending source is served normally.
        raise(0, 8'h5C); raise(1, 8'hC5);
        stub_dead = 1'b1;
        serve_one(scan(), 1'b1, 1'b0);
        stub_dead = 1'b0;
        stub_sd   = BT - 1;
        stub_len  = 2;
        serve_one(scan(), 1'b0, 1'b0);

        // TX busy in IDLE holds off the grant.
        tx_force = 1'b1;
        raise(1, 8'h3E);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("busy_hold_ready", 32'(req_ready), 32'(0));
            check("busy_hold_rq", 32'(tx_rq), 32'(0));
        end
        tx_force = 1'b0;
        stub_sd  = 0;
        serve_one(scan(), 1'b0, 1'b0);
        check("busy_release_latency", 32'(last_wait), 32'(1));

        // Reset during WAIT_END: frame continues in TX, no done, re-arbitration from ptr 0.
        stub_sd  = 0;
        stub_len = 20;
        raise(3, 8'h5A);
        n = 0;
        while (!mbusy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mptr  = 0;
        stub_len = 4;
        raise(1, 8'h77); raise(3, 8'h88);
        n = 0;
        while (tx_busy && n < 40) begin
            check("rst_hold_ready", 32'(req_ready), 32'(0));
            check("rst_hold_done", 32'(done), 32'(0));
            @(negedge clk);
            n++;
        end
        serve_one(scan(), 1'b0, 1'b0);
        serve_one(scan(), 1'b0, 1'b0);

        // Randomized frames against the round-robin model.
        for (int f = 0; f < 40; f++) begin
            int r;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) raise(i, SIZE'($urandom));
            end
            if ($urandom_range(0, 5) == 0) begin
                int d = $urandom_range(0, NREQ - 1);
                if (req_valid[d] && $countones(req_valid) > 1) req_valid[d] = 1'b0;
            end
            if (req_valid == '0) raise($urandom_range(0, NREQ - 1), SIZE'($urandom));
            r = $urandom_range(0, 9);
            stub_dead = (r == 0);
            stub_sd   = (r == 1) ? BT - 1 : $urandom_range(0, 3);
            stub_len  = $urandom_range(1, 6);
            serve_one(scan(), stub_dead, 1'b0);
            stub_dead = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
